// File: rtl/fifo_pop_ctrl_if.sv
// Pop-side bundle for fifo_pop_ctrl: FIFO read port plus downstream data/valid/pause.
// master = the controller; slave = the FIFO/consumer environment.
interface fifo_pop_ctrl_if #(
    parameter int unsigned DATA_SIZE = 8
);
    logic                 fifo_empty;
    logic                 almost_empty;
    logic [DATA_SIZE-1:0] data_out_pop;
    logic                 read;
    logic                 down_pause;
    logic [DATA_SIZE-1:0] data_out;
    logic                 valid_out;

    modport master (
        input  fifo_empty,
        input  almost_empty,
        input  data_out_pop,
        input  down_pause,
        output read,
        output data_out,
        output valid_out
    );

    modport slave (
        output fifo_empty,
        output almost_empty,
        output data_out_pop,
        output down_pause,
        input  read,
        input  data_out,
        input  valid_out
    );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO controller: registered pop strobe, 2-entry skid absorbing the 1-cycle read
// latency, bubble-free output. Optional pop counter enabled by defining POP_COUNT_EN.
module fifo_pop_ctrl #(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    fifo_pop_ctrl_if.master bus,
    output logic            underflow_err
`ifdef POP_COUNT_EN
    ,
    output logic [15:0]     pop_count
`endif
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] STALL  = 2'd2;

    localparam logic [2:0] DEPTH = 3'(SKID_DEPTH);

    logic [1:0]           state_q, state_d;
    logic                 read_q, read_d;
    logic                 inflight_q;
    logic [1:0]           cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] skid0_q, skid0_d;
    logic [DATA_SIZE-1:0] skid1_q, skid1_d;
    logic [DATA_SIZE-1:0] last_q, last_d;
    logic                 underflow_q, underflow_d;

    logic [2:0]           avail;
    logic [2:0]           occ;
    logic                 transfer;
    logic [DATA_SIZE-1:0] eff0, eff1;

    // The word landing from the FIFO this cycle is visible immediately (bypass),
    // so avail counts stored entries plus the in-flight word.
    always_comb begin
        avail    = {1'b0, cnt_q} + {2'b0, inflight_q};
        transfer = (avail != 3'd0) && !bus.down_pause;
        occ      = avail - {2'b0, transfer};
        eff0     = (cnt_q != 2'd0) ? skid0_q : bus.data_out_pop;
        eff1     = (cnt_q == 2'd2) ? skid1_q : bus.data_out_pop;

        skid0_d  = transfer ? eff1 : eff0;
        skid1_d  = transfer ? bus.data_out_pop : eff1;
        cnt_d    = occ[1:0];
        last_d   = (avail != 3'd0) ? eff0 : last_q;

        // Reserve room for the word already requested plus the one about to be requested.
        read_d   = !bus.fifo_empty
                && !(bus.almost_empty && read_q)
                && ((occ + {2'b0, read_q}) < DEPTH)
                && (state_q != STALL);

        underflow_d = underflow_q | (read_q & bus.fifo_empty);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read_d) state_d = STREAM;
            end
            STREAM: begin
                if (occ == DEPTH && bus.down_pause) begin
                    state_d = STALL;
                end else if (occ == 3'd0 && !read_q && bus.fifo_empty) begin
                    state_d = IDLE;
                end
            end
            STALL: begin
                if (!bus.down_pause) state_d = STREAM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            read_q      <= 1'b0;
            inflight_q  <= 1'b0;
            cnt_q       <= 2'd0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            last_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            inflight_q  <= read_q;
            cnt_q       <= cnt_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            last_q      <= last_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.read      = read_q;
    assign bus.valid_out = transfer;
    assign bus.data_out  = (avail != 3'd0) ? eff0 : last_q;
    assign underflow_err = underflow_q;

`ifdef POP_COUNT_EN
    logic [15:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q + {15'd0, transfer};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pop_count_q <= 16'd0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`endif
endmodule
